// File: rtl/note_tone_gen_if.sv
// Note/tone bundle between the sequence counter and the tone generator.
// master: strobe + index out, tone status in; slave: the reverse.
interface note_tone_gen_if #(
  parameter int BW = 8
);
  logic          strb_i;
  logic [BW-1:0] noteIndex_i;
  logic          tone_o;
  logic          active_o;
  logic [BW-1:0] note_o;

  modport master (
    output strb_i, noteIndex_i,
    input  tone_o, active_o, note_o
  );

  modport slave (
    input  strb_i, noteIndex_i,
    output tone_o, active_o, note_o
  );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave note generator: latches the note index after each strobe,
// waits a silent gap, then toggles tone at the scale table half-period.
// Ports: clk_i, rst_i (async, active-high), bus (slave: strb_i,
// noteIndex_i in; tone_o, active_o, note_o out).
module note_tone_gen #(
  parameter int BW         = 8,
  parameter int DIV_W      = 16,
  parameter int GAP_CYCLES = 256,
  parameter int GAP_W      = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  note_tone_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GAP,
    TONE
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic             strb_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] half_q;
  logic [GAP_W-1:0] gap_q;
  logic             rest_q;
  logic             tone_q;
  logic [BW-1:0]    note_q;

  logic [DIV_W-1:0] base;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] half_d;
  logic             rest_d;

  always_comb begin
    base = '0;
    unique case (bus.noteIndex_i[2:0])
      3'd0: base = DIV_W'(19111);
      3'd1: base = DIV_W'(17026);
      3'd2: base = DIV_W'(15169);
      3'd3: base = DIV_W'(14317);
      3'd4: base = DIV_W'(12755);
      3'd5: base = DIV_W'(11364);
      3'd6: base = DIV_W'(10124);
      3'd7: base = DIV_W'(9556);
    endcase
    shifted = base >> bus.noteIndex_i[5:3];
    half_d  = (shifted == '0) ? DIV_W'(1) : shifted;
    rest_d  = &bus.noteIndex_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: state_d = (GAP_CYCLES == 0) ? TONE : GAP;
      GAP:  if (gap_q == GAP_LAST) state_d = TONE;
      TONE: state_d = TONE;
    endcase
    // a new note aborts whatever is in progress
    if (strb_d && state_q != IDLE) state_d = LOAD;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      strb_d  <= 1'b0;
      div_q   <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      rest_q  <= 1'b0;
      tone_q  <= 1'b0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      strb_d  <= bus.strb_i;
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          note_q <= bus.noteIndex_i;
          half_q <= half_d;
          rest_q <= rest_d;
          gap_q  <= '0;
          div_q  <= '0;
          tone_q <= 1'b0;
        end
        GAP: begin
          gap_q <= gap_q + GAP_W'(1);
          div_q <= '0;
        end
        TONE: begin
          if (!rest_q) begin
            if (div_q == half_q - DIV_W'(1)) begin
              div_q  <= '0;
              tone_q <= ~tone_q;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end
        end
      endcase
    end
  end

  // gated by state so the pin goes quiet in the LOAD cycle itself
  assign bus.tone_o   = tone_q & (state_q == TONE) & ~rest_q;
  assign bus.active_o = (state_q == TONE) & ~rest_q;
  assign bus.note_o   = note_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Testbench for note_tone_gen: one instance with a 4-cycle gap, one
// with no gap; table vectors, random notes and hand-written sequences.
module tb_note_tone_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #50 clk = ~clk;

  note_tone_gen_if #(.BW(8)) if_a ();
  note_tone_gen_if #(.BW(8)) if_b ();

  note_tone_gen #(
    .BW(8), .DIV_W(16), .GAP_CYCLES(4), .GAP_W(16)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(if_a)
  );

  note_tone_gen #(
    .BW(8), .DIV_W(16), .GAP_CYCLES(0), .GAP_W(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(if_b)
  );

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int half;
    bit rest;
  } vec_t;

  vec_t vecs[8];

  // reference: table value divided by 2**octave, at least 1
  function automatic int ref_half(input int idx);
    int base[8];
    int h;
    base = '{19111, 17026, 15169, 14317, 12755, 11364, 10124, 9556};
    h = base[idx % 8] / (2 ** ((idx / 8) % 8));
    if (h < 1) h = 1;
    return h;
  endfunction

  function automatic int tone(input bit s);
    return s ? int'(if_b.tone_o) : int'(if_a.tone_o);
  endfunction

  function automatic int active(input bit s);
    return s ? int'(if_b.active_o) : int'(if_a.active_o);
  endfunction

  function automatic int note(input bit s);
    return s ? int'(if_b.note_o) : int'(if_a.note_o);
  endfunction

  task automatic drive(input bit s, input logic st, input int idx);
    if (s) begin
      if_b.strb_i = st;
      if_b.noteIndex_i = 8'(idx);
    end else begin
      if_a.strb_i = st;
      if_a.noteIndex_i = 8'(idx);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // one-cycle strobe; the counter presents the new index after the edge
  task automatic strobe(input bit s, input int idx);
    int cur;
    cur = s ? int'(if_b.noteIndex_i) : int'(if_a.noteIndex_i);
    @(negedge clk);
    drive(s, 1'b1, cur);
    @(negedge clk);
    drive(s, 1'b0, idx);
  endtask

  task automatic wait_toggle(input bit s, input int bound, output int cnt);
    int lvl;
    lvl = tone(s);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tone(s) == lvl && cnt < bound);
  endtask

  // called at the negedge just after the strobe edge (or reset release)
  task automatic follow(input bit s, input int idx, input int g,
                        input int h, input bit rest, input int nh);
    int bad;
    int cnt;
    int total;
    @(negedge clk);
    chk("load_tone", tone(s), 0);
    chk("load_active", active(s), 0);
    @(negedge clk);
    chk("note_latch", note(s), idx);
    bad = 0;
    for (int j = 2; j < 2 + g; j++) begin
      if (j > 2) @(negedge clk);
      if (tone(s) != 0 || active(s) != 0) bad++;
    end
    if (g > 0) begin
      chk("gap_silent", bad, 0);
      @(negedge clk);
    end
    chk("entry_active", active(s), rest ? 0 : 1);
    chk("entry_tone", tone(s), 0);
    if (rest) begin
      bad = 0;
      repeat (300) begin
        @(negedge clk);
        if (tone(s) != 0 || active(s) != 0) bad++;
      end
      chk("rest_silent", bad, 0);
    end else begin
      total = 0;
      for (int k = 0; k < nh; k++) begin
        wait_toggle(s, h + 16, cnt);
        chk("half_period", cnt, h);
        total += cnt;
      end
      if (nh >= 2) chk("full_period", total, 2 * h);
      chk("active_hold", active(s), 1);
    end
  endtask

  initial begin
    int idx;
    int bad;

    vecs[0] = '{idx: 8'h3F, half: 74,  rest: 1'b0};
    vecs[1] = '{idx: 8'h38, half: 149, rest: 1'b0};
    vecs[2] = '{idx: 8'h31, half: 266, rest: 1'b0};
    vecs[3] = '{idx: 8'h2A, half: 474, rest: 1'b0};
    vecs[4] = '{idx: 8'hFF, half: 1,   rest: 1'b1};
    vecs[5] = '{idx: 8'hFB, half: 111, rest: 1'b0};
    vecs[6] = '{idx: 8'h63, half: 894, rest: 1'b0};
    vecs[7] = '{idx: 8'h27, half: 597, rest: 1'b0};

    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("rst_tone", tone(0), 0);
    chk("rst_active", active(0), 0);
    chk("rst_note", note(0), 0);

    // reset release picks up note 0 through IDLE/LOAD
    rst_a = 1'b0;
    rst_b = 1'b0;
    follow(1'b0, 0, 4, 19111, 1'b0, 1);

    // abort a sounding tone
    repeat (100) @(negedge clk);
    chk("tone_before_abort", tone(0), 1);
    strobe(1'b0, 1);
    follow(1'b0, 1, 4, 17026, 1'b0, 1);

    // strobes on three consecutive cycles
    @(negedge clk);
    drive(1'b0, 1'b1, 1);
    @(negedge clk);
    drive(1'b0, 1'b1, 2);
    chk("b2b_still_tone", tone(0), 1);
    @(negedge clk);
    drive(1'b0, 1'b1, 3);
    chk("b2b_load1_tone", tone(0), 0);
    chk("b2b_load1_active", active(0), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4);
    chk("b2b_load2_tone", tone(0), 0);
    chk("b2b_note_mid", note(0), 3);
    follow(1'b0, 4, 4, ref_half(4), 1'b0, 1);

    strobe(1'b0, 8'h0D);
    follow(1'b0, 8'h0D, 4, 5682, 1'b0, 2);

    strobe(1'b0, 8'hFF);
    follow(1'b0, 8'hFF, 4, 1, 1'b1, 0);

    // no-gap instance: table of vectors
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, vecs[i].idx);
      follow(1'b1, vecs[i].idx, 0, vecs[i].half, vecs[i].rest, 2);
    end

    // random high-octave notes against the reference model
    for (int i = 0; i < 12; i++) begin
      idx = int'($urandom_range(0, 255));
      if (idx != 255) idx = idx | 8'h30;
      strobe(1'b1, idx);
      follow(1'b1, idx, 0, ref_half(idx), idx == 255, 2);
    end

    // asynchronous reset in the middle of a tone
    strobe(1'b1, 8'h3F);
    follow(1'b1, 8'h3F, 0, 74, 1'b0, 1);
    repeat (10) @(negedge clk);
    chk("tone_before_rst", tone(1), 1);
    @(posedge clk);
    #10;
    rst_b = 1'b1;
    #1;
    bad = tone(1) + active(1) + (note(1) != 0 ? 1 : 0);
    chk("async_rst_clear", bad, 0);
    @(negedge clk);
    rst_b = 1'b0;
    follow(1'b1, 8'h3F, 0, 74, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
